// File: rtl/wb_pkg.sv
// Shared definitions for the wishbone slave multiplexer.
package wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_ERR    = 2'd2
  } wb_state_e;

  // Index width for a slave count; at least one bit so a single slave still indexes.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_addr_match.sv
// Base/mask address comparator for one slave window.
module wb_addr_match #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] adr,
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic [ADDR_WIDTH-1:0] mask,
  output logic                  match
);

  assign match = ((adr & mask) == (base & mask));

endmodule

// File: rtl/wb_mux_n.sv
// One-master to N-slave wishbone multiplexer with decode,
// per-transfer timeout and a saturating error counter.
module wb_mux_n
  import wb_pkg::*;
#(
  parameter int NUM_SLAVES   = 4,
  parameter int DATA_WIDTH   = 128,
  parameter int ADDR_WIDTH   = 32,
  parameter int SELECT_WIDTH = DATA_WIDTH / 8,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_ADDR = '0,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = '0,
  parameter int TIMEOUT      = 255
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [ADDR_WIDTH-1:0]            wbm_adr_i,
  input  logic [DATA_WIDTH-1:0]            wbm_dat_i,
  output logic [DATA_WIDTH-1:0]            wbm_dat_o,
  input  logic                             wbm_we_i,
  input  logic [SELECT_WIDTH-1:0]          wbm_sel_i,
  input  logic                             wbm_stb_i,
  input  logic                             wbm_cyc_i,
  output logic                             wbm_ack_o,
  output logic                             wbm_err_o,
  output logic                             wbm_rty_o,
  output logic [NUM_SLAVES*ADDR_WIDTH-1:0] wbs_adr_o,
  output logic [NUM_SLAVES*DATA_WIDTH-1:0] wbs_dat_o,
  output logic [NUM_SLAVES-1:0]            wbs_we_o,
  output logic [NUM_SLAVES*SELECT_WIDTH-1:0] wbs_sel_o,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] wbs_dat_i,
  output logic [NUM_SLAVES-1:0]            wbs_stb_o,
  output logic [NUM_SLAVES-1:0]            wbs_cyc_o,
  input  logic [NUM_SLAVES-1:0]            wbs_ack_i,
  input  logic [NUM_SLAVES-1:0]            wbs_err_i,
  input  logic [NUM_SLAVES-1:0]            wbs_rty_i,
  output logic [15:0]                      err_count
);

  localparam int IW = idx_w(NUM_SLAVES);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  wb_state_e               state_q;
  wb_state_e               state_d;
  logic [IW-1:0]           sel_q;
  logic [TW-1:0]           timer_q;
  logic [15:0]             err_cnt_q;
  logic [NUM_SLAVES-1:0]   match;
  logic                    hit;
  logic [IW-1:0]           hit_idx;
  logic                    s_ack;
  logic                    s_err;
  logic                    s_rty;
  logic [DATA_WIDTH-1:0]   s_dat;
  logic                    s_resp;
  logic                    req;
  logic                    tmo;
  logic                    err_inc;

  for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_match
    wb_addr_match #(
      .ADDR_WIDTH(ADDR_WIDTH)
    ) u_match (
      .adr  (wbm_adr_i),
      .base (SLAVE_ADDR[g*ADDR_WIDTH +: ADDR_WIDTH]),
      .mask (SLAVE_MASK[g*ADDR_WIDTH +: ADDR_WIDTH]),
      .match(match[g])
    );
  end

  assign wbs_adr_o = {NUM_SLAVES{wbm_adr_i}};
  assign wbs_dat_o = {NUM_SLAVES{wbm_dat_i}};
  assign wbs_we_o  = {NUM_SLAVES{wbm_we_i}};
  assign wbs_sel_o = {NUM_SLAVES{wbm_sel_i}};
  assign err_count = err_cnt_q;

  // Descending scan so the lowest matching index is the last write.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
    end
  end

  always_comb begin
    s_ack = 1'b0;
    s_err = 1'b0;
    s_rty = 1'b0;
    s_dat = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q == IW'(i)) begin
        s_ack = wbs_ack_i[i];
        s_err = wbs_err_i[i];
        s_rty = wbs_rty_i[i];
        s_dat = wbs_dat_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign s_resp  = s_ack | s_err | s_rty;
  assign req     = wbm_cyc_i & wbm_stb_i;
  assign tmo     = (state_q == ST_ACTIVE) && (TIMEOUT != 0)
                && (timer_q == TW'(TIMEOUT - 1)) && !s_resp;
  assign err_inc = (state_q == ST_ERR) | tmo;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req) state_d = hit ? ST_ACTIVE : ST_ERR;
      end
      ST_ACTIVE: begin
        if (!wbm_cyc_i || s_resp || tmo) state_d = ST_IDLE;
      end
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wbm_ack_o = 1'b0;
    wbm_err_o = 1'b0;
    wbm_rty_o = 1'b0;
    wbm_dat_o = '0;
    wbs_cyc_o = '0;
    wbs_stb_o = '0;
    unique case (state_q)
      ST_ACTIVE: begin
        wbm_ack_o = s_ack;
        wbm_err_o = s_err | tmo;
        wbm_rty_o = s_rty;
        wbm_dat_o = s_dat;
        for (int i = 0; i < NUM_SLAVES; i++) begin
          if (sel_q == IW'(i) && !tmo) begin
            wbs_cyc_o[i] = wbm_cyc_i;
            wbs_stb_o[i] = wbm_cyc_i & wbm_stb_i;
          end
        end
      end
      ST_ERR:  wbm_err_o = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q     <= '0;
      timer_q   <= '0;
      err_cnt_q <= '0;
    end else begin
      if (state_q == ST_IDLE) begin
        timer_q <= '0;
        if (req && hit) sel_q <= hit_idx;
      end else if (state_q == ST_ACTIVE) begin
        timer_q <= timer_q + 1'b1;
      end
      if (err_inc && err_cnt_q != 16'hFFFF)
        err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

endmodule
